uart_rx: RTL and testbench

//   Serial receive stage of the UART: samples usb_rs232_rxd (8N1, LSB first) and delivers bytes
//   to the rest of the design over a valid/ack handshake. Upstream is the USB-RS232 bridge pin;

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial receive stage of the UART. Samples the USB-RS232 bridge pin (8N1,
//   LSB first) and hands completed bytes to the command/echo logic over a
//   valid/ack handshake. Framing errors and overwritten unacked bytes are
//   flagged with single-cycle pulses.
//
// Ports
//   user_clock    in   1  system clock, rising edge
//   rst           in   1  synchronous, active-high reset
//   usb_rs232_rxd in   1  asynchronous serial input, idles high
//   rx_ack        in   1  consumer has taken rx_data (ignored while rx_valid=0)
//   rx_data       out  8  last good byte, zero-extended above DATA_BITS
//   rx_valid      out  1  rx_data holds an unconsumed byte
//   rx_busy       out  1  receiver is not idle
//   rx_frame_err  out  1  pulse: stop bit sampled low
//   rx_overrun    out  1  pulse: new byte overwrote an unacked byte
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic       user_clock,
   input  logic       rst,
   input  logic       usb_rs232_rxd,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic                 rxd_meta_q;
   logic                 rxd_s_q;
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 load_d;
   logic                 ferr_d;
   logic [7:0]           data_ext;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_d;
   logic                 busy_q;
   logic                 ferr_q;
   logic                 ovr_q;

   // Receive FSM: counter is reused for the half-bit start check and for
   // each full bit period; samples land in the middle of every bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      load_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxd_s_q) begin
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CNT_MID) begin
               if (!rxd_s_q) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = S_DATA;
               end else begin
                  // Line went back high before mid start bit: a glitch.
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               // LSB arrives first, so shift in at the top and move right.
               shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               if (rxd_s_q) begin
                  load_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            // A low line here is a break or a bad frame, never a new start.
            if (rxd_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      data_ext                = '0;
      data_ext[DATA_BITS-1:0] = shift_q;
   end

   // Output handshake: a load always wins over an ack in the same cycle.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_d) begin
         data_d  = data_ext;
         valid_d = 1'b1;
      end else if (rx_ack && valid_q) begin
         valid_d = 1'b0;
      end
      ovr_d = load_d && valid_q && !rx_ack;
   end

   always_ff @(posedge user_clock) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rxd_meta_q <= usb_rs232_rxd;
         rxd_s_q    <= rxd_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         busy_q     <= (state_d != S_IDLE);
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   // Shift register is pure data; the FSM never reads it before refilling it.
   always_ff @(posedge user_clock) begin
      shift_q <= shift_d;
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_busy      = busy_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLKS_PER_BIT=16 and a 20 ns clock. A pin
//   BFM drives usb_rs232_rxd; expected bytes go into a scoreboard queue and a
//   monitor pops them as the receiver loads bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;

   int n_cmp   = 0;
   int n_err   = 0;
   int n_loads = 0;
   int n_ferr  = 0;
   int n_ovr   = 0;

   logic [7:0] exp_q[$];

   logic       prev_valid = 1'b0;
   logic       prev_ferr  = 1'b0;
   logic       prev_ovr   = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always #10 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .user_clock    (clk),
      .rst           (rst),
      .usb_rs232_rxd (rxd),
      .rx_ack        (ack),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one 8N1 frame; called on a negedge, returns on a negedge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag, input int budget, output int cycles);
      cycles = 0;
      while (!rx_valid && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check(tag, 32'(rx_valid), 32'd1);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic recv_ack(input string tag);
      int c;
      wait_valid({tag, "_valid"}, 400, c);
      ack_pulse();
      check({tag, "_cleared"}, 32'(rx_valid), 32'd0);
   endtask

   // Monitor: every byte load (valid rise, or new data while valid) pops the scoreboard.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid && (!prev_valid || rx_data != prev_data || rx_overrun)) begin
            n_loads++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e));
            end
         end
         if (rx_frame_err) begin
            n_ferr++;
            check("ferr_width", 32'(prev_ferr), 32'd0);
         end
         if (rx_overrun) begin
            n_ovr++;
            check("ovr_width", 32'(prev_ovr), 32'd0);
         end
         prev_valid = rx_valid;
         prev_ferr  = rx_frame_err;
         prev_ovr   = rx_overrun;
         prev_data  = rx_data;
      end
   end

   initial begin
      int lat;
      int l0;
      int k;
      logic seen;
      logic [7:0] b81;

      rst = 1'b1;
      rxd = 1'b1;
      ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data",  32'(rx_data),      32'd0);
      check("rst_valid", 32'(rx_valid),     32'd0);
      check("rst_busy",  32'(rx_busy),      32'd0);
      check("rst_ferr",  32'(rx_frame_err), 32'd0);
      check("rst_ovr",   32'(rx_overrun),   32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: single byte, ack three cycles after valid
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            wait_valid("t1_valid", 400, lat);
            check("t1_latency", 32'(lat >= 154 && lat <= 156), 32'd1);
            repeat (2) @(negedge clk);
            check("t1_valid_hold", 32'(rx_valid), 32'd1);
            ack_pulse();
            check("t1_valid_drop", 32'(rx_valid), 32'd0);
         end
      join
      check("t1_ferr_cnt", 32'(n_ferr), 32'd0);
      check("t1_ovr_cnt",  32'(n_ovr),  32'd0);
      repeat (5) @(negedge clk);

      // 2: back-to-back 0x00, 0xFF
      l0 = n_loads;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
         end
         begin
            recv_ack("t2_00");
            recv_ack("t2_ff");
         end
      join
      check("t2_loads", 32'(n_loads - l0), 32'd2);
      check("t2_ferr_cnt", 32'(n_ferr), 32'd0);
      check("t2_ovr_cnt",  32'(n_ovr),  32'd0);
      repeat (5) @(negedge clk);

      // 3: short low glitch
      l0 = n_loads;
      seen = 1'b0;
      rxd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rx_busy) seen = 1'b1;
      end
      rxd = 1'b1;
      check("t3_busy_rise", 32'(seen), 32'd1);
      k = 0;
      while (rx_busy && k < HALF + 3) begin
         @(negedge clk);
         k++;
      end
      check("t3_busy_drop", 32'(rx_busy), 32'd0);
      repeat (30) @(negedge clk);
      check("t3_no_valid", 32'(rx_valid), 32'd0);
      check("t3_no_load", 32'(n_loads), 32'(l0));

      // 4: framing error with held-low line, then a good frame
      l0 = n_loads;
      send_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      rxd = 1'b1;
      repeat (10) @(negedge clk);
      check("t4_ferr_cnt", 32'(n_ferr), 32'd1);
      check("t4_valid", 32'(rx_valid), 32'd0);
      check("t4_no_load", 32'(n_loads), 32'(l0));
      exp_q.push_back(8'h55);
      fork
         send_frame(8'h55, 1'b1);
         recv_ack("t4_55");
      join
      check("t4_ferr_once", 32'(n_ferr), 32'd1);
      repeat (5) @(negedge clk);

      // 5a: overrun when the first byte is never acked
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("t5_ovr_cnt", 32'(n_ovr), 32'd1);
      check("t5_data", 32'(rx_data), 32'h22);
      check("t5_valid", 32'(rx_valid), 32'd1);
      ack_pulse();
      check("t5_cleared", 32'(rx_valid), 32'd0);
      repeat (5) @(negedge clk);

      // 5b: ack coincides with the load edge of the next byte
      exp_q.push_back(8'h33);
      send_frame(8'h33, 1'b1);
      exp_q.push_back(8'h44);
      fork
         send_frame(8'h44, 1'b1);
         begin
            repeat (154) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
         end
      join
      check("t5b_ovr_cnt", 32'(n_ovr), 32'd1);
      check("t5b_valid", 32'(rx_valid), 32'd1);
      check("t5b_data", 32'(rx_data), 32'h44);
      repeat (5) @(negedge clk);

      // 6: reset during data bit 3 of 0x81 (0x44 still pending)
      l0 = n_loads;
      b81 = 8'h81;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rxd = b81[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = b81[3];
      repeat (HALF) @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_data",  32'(rx_data),      32'd0);
      check("t6_valid", 32'(rx_valid),     32'd0);
      check("t6_busy",  32'(rx_busy),      32'd0);
      check("t6_ferr",  32'(rx_frame_err), 32'd0);
      check("t6_ovr",   32'(rx_overrun),   32'd0);
      repeat (40) @(negedge clk);
      check("t6_no_load", 32'(n_loads), 32'(l0));
      exp_q.push_back(8'h7E);
      fork
         send_frame(8'h7E, 1'b1);
         recv_ack("t6_7e");
      join
      repeat (5) @(negedge clk);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("final_ovr_cnt", 32'(n_ovr), 32'd1);
      check("final_ferr_cnt", 32'(n_ferr), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
